// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants, ALU opcodes, forward-select encoding and stage payloads.
package mips_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_AW     = 5;
  localparam int unsigned SHAMT_W    = 5;
  localparam int unsigned ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'd0;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'd1;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'd2;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'd6;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'd7;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'd11;
  localparam logic [ALU_CTRL_W-1:0] ALU_NOR  = 4'd12;
  localparam logic [ALU_CTRL_W-1:0] ALU_XNOR = 4'd13;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'd14;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'd15;

  // Operand source chosen by the forwarding unit.
  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  // Control bits carried from ID into EX.
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
  } ex_ctrl_t;

endpackage

// File: rtl/fwd_unit.sv
// Forward-select generation for two source operands; EX/MEM beats MEM/WB, r0 never forwards.
module fwd_unit
  import mips_pkg::*;
#(
  parameter int unsigned REG_AW = mips_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  output fwd_sel_e          sel_rs_c,
  output fwd_sel_e          sel_rt_c
);

  logic mem_ok_c;
  logic wb_ok_c;

  assign mem_ok_c = exmem_reg_write && (exmem_rd != '0);
  assign wb_ok_c  = memwb_reg_write && (memwb_rd != '0);

  // Independent priority select for each operand.
  always_comb begin
    sel_rs_c = FWD_REG;
    sel_rt_c = FWD_REG;
    if (mem_ok_c && (exmem_rd == rs))     sel_rs_c = FWD_MEM;
    else if (wb_ok_c && (memwb_rd == rs)) sel_rs_c = FWD_WB;
    if (mem_ok_c && (exmem_rd == rt))     sel_rt_c = FWD_MEM;
    else if (wb_ok_c && (memwb_rd == rt)) sel_rt_c = FWD_WB;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and ALU operand forwarding.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned REG_AW = mips_pkg::REG_AW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [REG_AW-1:0]     id_rs,
  input  logic [REG_AW-1:0]     id_rt,
  input  logic [REG_AW-1:0]     id_rd,
  input  logic [SHAMT_W-1:0]    id_shamt,
  input  logic [ALU_CTRL_W-1:0] id_alu_ctrl,
  input  logic                  id_alu_src,
  input  logic                  id_reg_dst,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_mem_to_reg,
  input  logic                  exmem_reg_write,
  input  logic [REG_AW-1:0]     exmem_rd,
  input  logic [DATA_W-1:0]     exmem_alu_out,
  input  logic                  memwb_reg_write,
  input  logic [REG_AW-1:0]     memwb_rd,
  input  logic [DATA_W-1:0]     memwb_data,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic [SHAMT_W-1:0]    alu_shamt,
  output logic [DATA_W-1:0]     ex_store_data,
  output logic [REG_AW-1:0]     ex_dest,
  output logic                  ex_valid,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg,
  output logic                  load_use_hazard
);

  logic [DATA_W-1:0]     rs_data_q;
  logic [DATA_W-1:0]     rt_data_q;
  logic [DATA_W-1:0]     imm_q;
  logic [REG_AW-1:0]     rs_q;
  logic [REG_AW-1:0]     rt_q;
  logic [REG_AW-1:0]     dest_q;
  logic [SHAMT_W-1:0]    shamt_q;
  logic [ALU_CTRL_W-1:0] alu_ctrl_q;
  ex_ctrl_t              ctrl_q;

  ex_ctrl_t              ctrl_d;
  logic [DATA_W-1:0]     rs_capture_c;
  logic [DATA_W-1:0]     rt_capture_c;
  logic                  wb_through_ok_c;
  logic                  bubble_c;
  fwd_sel_e              sel_rs_c;
  fwd_sel_e              sel_rt_c;
  logic [DATA_W-1:0]     fwd_rs_c;
  logic [DATA_W-1:0]     fwd_rt_c;

  // A load in EX whose destination feeds the instruction in ID must wait a cycle.
  assign load_use_hazard = ~stall & id_valid & ctrl_q.valid & ctrl_q.mem_read &
                           (dest_q != '0) & ((dest_q == id_rs) | (dest_q == id_rt));

  assign bubble_c = flush | load_use_hazard;

  // Decoded control is only meaningful for a real instruction.
  always_comb begin
    ctrl_d            = '0;
    ctrl_d.valid      = id_valid;
    ctrl_d.reg_write  = id_reg_write  & id_valid;
    ctrl_d.mem_read   = id_mem_read   & id_valid;
    ctrl_d.mem_write  = id_mem_write  & id_valid;
    ctrl_d.mem_to_reg = id_mem_to_reg & id_valid;
    ctrl_d.alu_src    = id_alu_src    & id_valid;
  end

  // Register-file write in the same cycle as the read: take the value being written.
  assign wb_through_ok_c = memwb_reg_write && (memwb_rd != '0);
  always_comb begin
    rs_capture_c = id_rs_data;
    rt_capture_c = id_rt_data;
    if (wb_through_ok_c && (memwb_rd == id_rs)) rs_capture_c = memwb_data;
    if (wb_through_ok_c && (memwb_rd == id_rt)) rt_capture_c = memwb_data;
  end

  // Stage register: reset > stall hold > bubble > capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      dest_q     <= '0;
      shamt_q    <= '0;
      alu_ctrl_q <= '0;
      ctrl_q     <= '0;
    end else if (stall) begin
      rs_data_q  <= rs_data_q;
      rt_data_q  <= rt_data_q;
      imm_q      <= imm_q;
      rs_q       <= rs_q;
      rt_q       <= rt_q;
      dest_q     <= dest_q;
      shamt_q    <= shamt_q;
      alu_ctrl_q <= alu_ctrl_q;
      ctrl_q     <= ctrl_q;
    end else if (bubble_c) begin
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      dest_q     <= '0;
      shamt_q    <= '0;
      alu_ctrl_q <= '0;
      ctrl_q     <= '0;
    end else begin
      rs_data_q  <= rs_capture_c;
      rt_data_q  <= rt_capture_c;
      imm_q      <= id_imm;
      rs_q       <= id_rs;
      rt_q       <= id_rt;
      dest_q     <= id_reg_dst ? id_rd : id_rt;
      shamt_q    <= id_shamt;
      alu_ctrl_q <= id_alu_ctrl;
      ctrl_q     <= ctrl_d;
    end
  end

  fwd_unit #(
    .REG_AW(REG_AW)
  ) u_fwd (
    .rs              (rs_q),
    .rt              (rt_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .sel_rs_c        (sel_rs_c),
    .sel_rt_c        (sel_rt_c)
  );

  // Operand muxes driven by the forward selects.
  always_comb begin
    fwd_rs_c = rs_data_q;
    fwd_rt_c = rt_data_q;
    case (sel_rs_c)
      FWD_MEM: fwd_rs_c = exmem_alu_out;
      FWD_WB:  fwd_rs_c = memwb_data;
      default: fwd_rs_c = rs_data_q;
    endcase
    case (sel_rt_c)
      FWD_MEM: fwd_rt_c = exmem_alu_out;
      FWD_WB:  fwd_rt_c = memwb_data;
      default: fwd_rt_c = rt_data_q;
    endcase
  end

  assign alu_a         = fwd_rs_c;
  assign alu_b         = ctrl_q.alu_src ? imm_q : fwd_rt_c;
  assign ex_store_data = fwd_rt_c;
  assign alu_ctrl      = alu_ctrl_q;
  assign alu_shamt     = shamt_q;
  assign ex_dest       = dest_q;
  assign ex_valid      = ctrl_q.valid;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;

endmodule
